// File: rtl/axis_trim_pkg.sv
// Shared types and widths for the AXI-Stream packet trimmer.
// Holds the trimmer FSM encoding and the counter/config widths.
package axis_trim_pkg;

  localparam int CFG_W  = 8;
  localparam int CNT_W  = 8;
  localparam int STAT_W = 16;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } trim_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, full throughput, no loss under back-pressure.
// The main register drives the output, and the skid register catches the beat in flight when a stall begins.
module axis_skid_buffer #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] main_data;
  logic             main_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  always_ff @(posedge clk) begin
    if (areset) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (!skid_valid) begin
      if (!main_valid || out_ready) begin
        main_valid <= in_valid;
        if (in_valid) main_data <= in_data;
      end else if (in_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end else if (out_ready) begin
      // Skid is full, so the upstream side is stalled and the skid beat moves into main.
      main_data  <= skid_data;
      skid_valid <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_data  = main_data;
  assign out_valid = main_valid;

endmodule

// File: rtl/axis_pkt_trimmer.sv
// AXI-Stream packet trimmer: limits packets to a configurable beat count.
// Beats past the limit are dropped, and the last kept beat is forced to carry tlast.
module axis_pkt_trimmer
  import axis_trim_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int KEEP_WIDTH      = 8,
  parameter int DEFAULT_MAX_LEN = 64
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [CFG_W-1:0]      config_in_tdata,
  input  logic                  config_in_tvalid,
  output logic                  config_in_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [STAT_W-1:0]     pkt_count,
  output logic [STAT_W-1:0]     trunc_count,
  output trim_state_t           fsm_state
);

  localparam int BEAT_W = DATA_WIDTH + KEEP_WIDTH + 1;

  // Every port pair moves a beat only on a rising edge where valid and ready are both high;
  // a source holds its payload stable while valid is high and ready is low.

  trim_state_t       state_q;
  logic [CFG_W-1:0]  cfg_max;
  logic [CFG_W-1:0]  active_max;
  logic [CNT_W-1:0]  beat_cnt;
  logic [STAT_W-1:0] pkt_q;
  logic [STAT_W-1:0] trunc_q;
  logic              skid_in_ready;
  logic              accept;
  logic              fwd;
  logic              limit_hit;
  logic              last_out;
  logic [BEAT_W-1:0] skid_out;

  assign config_in_tready = !areset;
  assign s_axis_tready    = !areset && ((state_q == ST_DROP) || skid_in_ready);
  assign accept           = s_axis_tvalid && s_axis_tready;
  assign fwd              = accept && (state_q != ST_DROP);

  always_comb begin
    limit_hit = 1'b0;
    case (state_q)
      ST_IDLE: limit_hit = (cfg_max == CFG_W'(1));
      ST_PASS: limit_hit = (active_max != '0) &&
                           (({1'b0, beat_cnt} + 9'd1) == {1'b0, active_max});
      default: limit_hit = 1'b0;
    endcase
  end

  assign last_out = s_axis_tlast || limit_hit;

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      cfg_max    <= CFG_W'(DEFAULT_MAX_LEN);
      active_max <= CFG_W'(DEFAULT_MAX_LEN);
      beat_cnt   <= '0;
      pkt_q      <= '0;
      trunc_q    <= '0;
    end else begin
      if (config_in_tvalid) cfg_max <= config_in_tdata;
      if (fwd && last_out) pkt_q <= pkt_q + 16'd1;
      if (fwd && limit_hit && !s_axis_tlast) trunc_q <= trunc_q + 16'd1;
      if (accept) begin
        case (state_q)
          ST_IDLE: begin
            // The limit that is latched here uses cfg_max from before this edge's config write.
            active_max <= cfg_max;
            beat_cnt   <= CNT_W'(1);
            if (s_axis_tlast)   state_q <= ST_IDLE;
            else if (limit_hit) state_q <= ST_DROP;
            else                state_q <= ST_PASS;
          end
          ST_PASS: begin
            if (beat_cnt != CNT_SAT) beat_cnt <= beat_cnt + CNT_W'(1);
            if (s_axis_tlast)   state_q <= ST_IDLE;
            else if (limit_hit) state_q <= ST_DROP;
          end
          ST_DROP: begin
            if (s_axis_tlast) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  axis_skid_buffer #(
    .WIDTH(BEAT_W)
  ) u_skid (
    .clk      (clk),
    .areset   (areset),
    .in_data  ({s_axis_tdata, s_axis_tkeep, last_out}),
    .in_valid (fwd),
    .in_ready (skid_in_ready),
    .out_data (skid_out),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready)
  );

  assign m_axis_tdata = skid_out[BEAT_W-1 -: DATA_WIDTH];
  assign m_axis_tkeep = skid_out[KEEP_WIDTH:1];
  assign m_axis_tlast = skid_out[0];
  assign pkt_count    = pkt_q;
  assign trunc_count  = trunc_q;
  assign fsm_state    = state_q;

endmodule

// File: doc/axis_pkt_trimmer.md
AXIS_PKT_TRIMMER -- requirements
Module: axis_pkt_trimmer

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of tdata.
REQ-002 Parameter KEEP_WIDTH, 8, width of tkeep.
REQ-003 Parameter DEFAULT_MAX_LEN, 64, max beats per packet after reset (0 = unlimited).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  reset, synchronous, active-high (sampled on clk).
REQ-006 config_in_tdata  in  8  new max packet length in beats (0 = unlimited).
REQ-007 config_in_tvalid  in  1  config valid.
REQ-008 config_in_tready  out  1  config ready.
REQ-009 s_axis_tdata / s_axis_tkeep / s_axis_tlast  in  DATA_WIDTH / KEEP_WIDTH / 1  upstream beat from the framing stage.
REQ-010 s_axis_tvalid  in  1; s_axis_tready  out  1  upstream handshake.
REQ-011 m_axis_tdata / m_axis_tkeep / m_axis_tlast  out  DATA_WIDTH / KEEP_WIDTH / 1  trimmed stream.
REQ-012 m_axis_tvalid  out  1; m_axis_tready  in  1  downstream handshake.
REQ-013 pkt_count  out  16  output packets completed (wraps 0xFFFF->0).
REQ-014 trunc_count  out  16  packets truncated (wraps 0xFFFF->0).

Function
REQ-015 Beat transfers only when valid and ready are both high on a rising clk edge; tdata/tkeep/tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-016 Config handshake: config_in_tready=1 whenever areset=0; accepted value is written to cfg_max.
REQ-017 cfg_max is latched into active_max when the first beat of a packet is accepted; a config accepted in the same cycle as a first beat affects the next packet only.
REQ-018 States: IDLE (no beat of current packet accepted), PASS (mid-packet, forwarding), DROP (limit reached, discarding remainder).
REQ-019 IDLE, beat accepted: tlast=1 -> IDLE; else cfg_max=1 -> force output tlast, DROP; else PASS with beat count=1.
REQ-020 PASS, beat accepted: count+1; tlast=1 -> IDLE; else count+1==active_max -> force output tlast, DROP.
REQ-021 Input tlast on the exact limit beat is a normal end: no DROP, no trunc_count increment.
REQ-022 DROP: s_axis_tready=1 regardless of output state; beats are discarded; input tlast -> IDLE.
REQ-023 trunc_count increments on entry to DROP; pkt_count increments on every accepted input beat that produces an output beat with tlast=1.
REQ-024 active_max=0 means unlimited; beat count saturates at 255 and never forces tlast.
REQ-025 Forwarded beats carry tdata and tkeep unmodified, including the forced-tlast beat.
REQ-026 Latency: accepted beat appears on m_axis one cycle later; full throughput (one beat/cycle) with m_axis_tready=1.
REQ-027 In IDLE/PASS, s_axis_tready is a registered signal (no combinational path from m_axis_tready); 2-entry skid buffer absorbs back-pressure with no beat loss or duplication.

Reset
REQ-028 While areset=1: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0, config_in_tready=0, pkt_count=0, trunc_count=0, state=IDLE, cfg_max=DEFAULT_MAX_LEN, skid buffer empty.
REQ-029 Reset mid-packet discards buffered beats; the output packet is left unterminated (downstream shares the reset).

Structure
REQ-030 Package axis_trim_pkg holds the state encoding (IDLE/PASS/DROP) and the count/config width constants.
REQ-031 One sub-module, axis_skid_buffer (2-entry, DATA_WIDTH+KEEP_WIDTH+1 bits), provides the output register stage.

Verification
REQ-032 cfg 40, 16-beat packet with tlast on beat 16, m_axis_tready=1 -> 16 beats out, tlast on 16th, pkt_count=1, trunc_count=0.
REQ-033 cfg 4, 10-beat packet -> 4 beats out with tlast forced on 4th, beats 5-10 dropped, trunc_count=1, pkt_count=1.
REQ-034 cfg 8, 8-beat packet with input tlast on beat 8 -> 8 beats out, trunc_count=0.
REQ-035 cfg 40, continuous input, m_axis_tready low 30 cycles then high 10, low 2, high -> output sequence equals input sequence, no loss/duplication, tkeep values (4/8/12) preserved.
REQ-036 cfg 2 accepted in same cycle as first beat of packet A (cfg_max was 40), A and B 5 beats each -> A passes 5 beats, B truncated to 2.
REQ-037 areset asserted mid-packet in PASS for 1 cycle -> all outputs at reset values next cycle; next packet uses DEFAULT_MAX_LEN=64.
